uart_bus_bridge: RTL
====================

// Module: uart_bus_bridge
// PURPOSE
//  Byte-stream debug/loader initiator for the SoC cmd/rsp bus: decodes host command packets arriving
//  as bytes from a UART receiver and issues word reads/writes on the same cmd/rsp stream the CPU uses,
//  returning ack/read data as bytes to a UART transmitter. Sits between the UART byte interface and a
//  bus arbiter port; lets a PC load firmware or poke MMIO (USB, timers) without the CPU.
// PARAMETERS
//  BYTE_TIMEOUT  480000  max idle cycles between bytes inside a packet before abort (10 ms @ 48 MHz)
// PORTS
//  clk            in   1   clock
//  resetn         in   1   reset, synchronous, active-low
//  rx_valid       in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data        in   8   received byte
//  tx_valid       out  1   tx_data valid; held until tx_ready
//  tx_ready       in   1   transmitter accepts byte this cycle when tx_valid&&tx_ready
//  tx_data        out  8   byte to transmit
//  bus_cmd_valid  out  1   bus command request; held with payload stable until bus_cmd_ready
//  bus_cmd_ready  in   1   command accepted this cycle when valid&&ready
//  bus_cmd_wr     out  1   1=write, 0=read
//  bus_cmd_addr   out  32  byte address, bits[1:0] forced 0
//  bus_cmd_data   out  32  write data
//  bus_cmd_size   out  2   constant 2'b10 (word)
//  bus_rsp_valid  in   1   read data valid (any cycle after accepted read cmd)
//  bus_rsp_data   in   32  read data
//  busy           out  1   1 whenever state != IDLE
//  overrun        out  1   sticky: byte arrived while bridge not accepting bytes; cleared only by reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet/mid-bus-op aborts immediately;
//   outstanding bus_rsp_valid after reset is ignored.
//  Packets (multi-byte fields little-endian):
//   0x01 WRITE: op, A0..A3, D0..D3 -> bus write; reply 0x06 after cmd accepted
//   0x02 READ : op, A0..A3        -> bus read; reply R0..R3 (rsp data, LSB first)
//   0x03 PING : op                -> reply 0xA5
//   other op  -> reply 0xEE, return to IDLE
//  FSM: IDLE -> ADDR (4 bytes) -> [DATA (4 bytes), WRITE only] -> CMD -> [RSP, READ only] -> TX -> IDLE.
//   IDLE: rx_valid latches opcode; PING/unknown go straight to TX with 1-byte reply.
//   ADDR/DATA: byte counter 0..3 shifts byte into [8*cnt+:8]; after 4th byte advance.
//   CMD: bus_cmd_valid=1; on bus_cmd_ready -> WRITE: TX(0x06); READ: RSP. Min 1 cycle in CMD.
//   RSP: wait bus_rsp_valid (no timeout); capture bus_rsp_data, -> TX with 4 bytes.
//   TX: present bytes in order, advance on tx_valid&&tx_ready; after last -> IDLE.
//  Inter-byte timeout: in ADDR/DATA, counter resets on each rx_valid; reaching BYTE_TIMEOUT -> IDLE,
//   partial packet discarded, no reply. Counter idle (0) in all other states.
//  rx_valid in CMD/RSP/TX sets overrun; byte discarded. rx_valid on the cycle TX->IDLE transition
//   completes is also dropped (accept only when state==IDLE at the edge).
//  bus_cmd_* payload registers stable throughout CMD; bus_cmd_valid never deasserts before ready.
//  Latency: last packet byte -> bus_cmd_valid 1 cycle; bus_rsp_valid -> tx_valid 1 cycle.
// TESTING
//  PING: rx 0x03 -> tx 0xA5 once, busy back to 0, no bus_cmd_valid.
//  WRITE: rx 01 00 10 00 00 EF BE AD DE, ready after 2 stall cycles -> one cmd wr=1 addr=0x00001000
//   data=0xDEADBEEF size=2, valid held over stall, then tx 0x06.
//  READ: rx 02 13 00 00 02, rsp 0x12345678 3 cycles after accept -> addr=0x02000010 (bits[1:0]=0),
//   wr=0, tx 78 56 34 12 in order with tx_ready toggling every other cycle.
//  Timeout: rx 02 00 then silence BYTE_TIMEOUT cycles -> IDLE, no bus cmd, no tx; next 0x03 -> 0xA5.
//  Unknown/overrun: rx 0x7F -> tx 0xEE; rx byte during TX of read reply -> overrun=1, reply intact.
//  Reset mid-RSP: resetn low 1 cycle while waiting rsp -> all outputs 0; late rsp_valid ignored.

Source files
------------

// File: rtl/uart_bus_bridge.sv
// Byte-stream command decoder that turns host packets from a UART receiver into word reads/writes
// on the cmd/rsp bus, returning an ack byte or read data to a UART transmitter.
module uart_bus_bridge #(
  parameter int BYTE_TIMEOUT = 480000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        bus_cmd_valid,
  input  logic        bus_cmd_ready,
  output logic        bus_cmd_wr,
  output logic [31:0] bus_cmd_addr,
  output logic [31:0] bus_cmd_data,
  output logic [1:0]  bus_cmd_size,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  output logic        busy,
  output logic        overrun
);

  localparam int TW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(BYTE_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CMD  = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;
  localparam logic [2:0] S_TX   = 3'd5;

  logic [2:0]    state_reg;
  logic          wr_reg;
  logic [1:0]    cnt_reg;
  logic [TW-1:0] timer_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   data_reg;
  logic [31:0]   tx_buf_reg;
  logic [1:0]    tx_left_reg;
  logic          overrun_reg;
  logic          rx_blocked;
  logic          timed_out;

  assign rx_blocked = (state_reg == S_CMD) || (state_reg == S_RSP) || (state_reg == S_TX);
  // A byte arriving on the deadline cycle still counts, so the abort needs silence too.
  assign timed_out  = (timer_reg == TIMEOUT_LAST) && !rx_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg   <= S_IDLE;
      wr_reg      <= 1'b0;
      cnt_reg     <= 2'd0;
      timer_reg   <= '0;
      addr_reg    <= 32'd0;
      data_reg    <= 32'd0;
      tx_buf_reg  <= 32'd0;
      tx_left_reg <= 2'd0;
      overrun_reg <= 1'b0;
    end else begin
      if (rx_valid && rx_blocked)
        overrun_reg <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          cnt_reg   <= 2'd0;
          timer_reg <= '0;
          if (rx_valid) begin
            case (rx_data)
              8'h01: begin wr_reg <= 1'b1; state_reg <= S_ADDR; end
              8'h02: begin wr_reg <= 1'b0; state_reg <= S_ADDR; end
              8'h03: begin
                tx_buf_reg  <= 32'h0000_00A5;
                tx_left_reg <= 2'd0;
                state_reg   <= S_TX;
              end
              default: begin
                tx_buf_reg  <= 32'h0000_00EE;
                tx_left_reg <= 2'd0;
                state_reg   <= S_TX;
              end
            endcase
          end
        end
        S_ADDR, S_DATA: begin
          if (rx_valid) begin
            if (state_reg == S_ADDR)
              addr_reg[{cnt_reg, 3'b000} +: 8] <= rx_data;
            else
              data_reg[{cnt_reg, 3'b000} +: 8] <= rx_data;
            cnt_reg   <= cnt_reg + 2'd1;
            timer_reg <= '0;
            if (cnt_reg == 2'd3)
              state_reg <= (state_reg == S_ADDR && wr_reg) ? S_DATA : S_CMD;
          end else if (timed_out) begin
            state_reg <= S_IDLE;
            timer_reg <= '0;
            cnt_reg   <= 2'd0;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_CMD: begin
          if (bus_cmd_ready) begin
            if (wr_reg) begin
              tx_buf_reg  <= 32'h0000_0006;
              tx_left_reg <= 2'd0;
              state_reg   <= S_TX;
            end else begin
              state_reg <= S_RSP;
            end
          end
        end
        S_RSP: begin
          if (bus_rsp_valid) begin
            tx_buf_reg  <= bus_rsp_data;
            tx_left_reg <= 2'd3;
            state_reg   <= S_TX;
          end
        end
        S_TX: begin
          // Reply bytes leave LSB first; the buffer shifts down one byte per handshake.
          if (tx_ready) begin
            tx_buf_reg <= {8'h00, tx_buf_reg[31:8]};
            if (tx_left_reg == 2'd0)
              state_reg <= S_IDLE;
            else
              tx_left_reg <= tx_left_reg - 2'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign tx_valid      = (state_reg == S_TX);
  assign tx_data       = tx_buf_reg[7:0];
  assign bus_cmd_valid = (state_reg == S_CMD);
  assign bus_cmd_wr    = wr_reg;
  assign bus_cmd_addr  = addr_reg & 32'hFFFF_FFFC;
  assign bus_cmd_data  = data_reg;
  assign bus_cmd_size  = 2'b10;
  assign busy          = (state_reg != S_IDLE);
  assign overrun       = overrun_reg;

endmodule
